// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator: command opcodes and error causes.
package rpn_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'b000,
        CMD_PUSH = 3'b001,
        CMD_NEG  = 3'b010,
        CMD_ADD  = 3'b011,
        CMD_SUB  = 3'b100,
        CMD_MUL  = 3'b101,
        CMD_SWAP = 3'b110,
        CMD_POP  = 3'b111
    } cmd_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_UNDER = 2'b01,
        ERR_OVER  = 2'b10
    } err_t;

endpackage

// File: rtl/stack_mem.sv
// Storage for stack entries below the top: synchronous write, asynchronous read, no reset.
module stack_mem #(
    parameter int W     = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          step,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write port; a same-cycle read of the written address still sees the old word.
    always_ff @(posedge step) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rpn_calc.sv
// RPN stack calculator: top-of-stack register, entry counter, sticky error and command decode.
module rpn_calc
    import rpn_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          step,
    input  logic          nrst,
    input  logic          en,
    input  logic [2:0]    cmd,
    input  logic          clr,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  out,
    output logic [AW:0]   cnt,
    output logic          err,
    output logic [1:0]    err_code
);

    logic [W-1:0]  out_q, out_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    err_t          err_code_q, err_code_d;

    logic          we_s;
    logic [AW-1:0] waddr_s;
    logic [W-1:0]  wdata_s;
    logic [AW-1:0] top_addr_s;
    logic [AW-1:0] sec_addr_s;
    logic [W-1:0]  sec_s;
    logic          has1_s, has2_s, full_s;
    cmd_t          cmd_s;

    assign cmd_s      = cmd_t'(cmd);
    // The top entry is in out_q, so memory holds cnt-1 entries; wrap at DEPTH is harmless.
    assign top_addr_s = cnt_q[AW-1:0] - AW'(1);
    assign sec_addr_s = cnt_q[AW-1:0] - AW'(2);
    assign has1_s     = (cnt_q != (AW+1)'(0));
    assign has2_s     = (cnt_q >= (AW+1)'(2));
    assign full_s     = (cnt_q == (AW+1)'(DEPTH));

    stack_mem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .step  (step),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (sec_addr_s),
        .rdata (sec_s)
    );

    // Command decode: next state of top, count, error and the memory write.
    always_comb begin
        out_d      = out_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        we_s       = 1'b0;
        waddr_s    = top_addr_s;
        wdata_s    = out_q;
        if (clr) begin
            out_d      = '0;
            cnt_d      = '0;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end else if (en && !err_q) begin
            case (cmd_s)
                CMD_NOP: begin
                    out_d = out_q;
                end
                CMD_PUSH: begin
                    if (full_s) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_OVER;
                    end else begin
                        we_s  = has1_s;
                        out_d = d;
                        cnt_d = cnt_q + (AW+1)'(1);
                    end
                end
                CMD_NEG: begin
                    if (!has1_s) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_UNDER;
                    end else begin
                        out_d = -out_q;
                    end
                end
                CMD_ADD, CMD_SUB, CMD_MUL: begin
                    if (!has2_s) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_UNDER;
                    end else begin
                        cnt_d = cnt_q - (AW+1)'(1);
                        if (cmd_s == CMD_ADD) begin
                            out_d = sec_s + out_q;
                        end else if (cmd_s == CMD_SUB) begin
                            out_d = sec_s - out_q;
                        end else begin
                            out_d = sec_s * out_q;
                        end
                    end
                end
                CMD_SWAP: begin
                    if (!has2_s) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_UNDER;
                    end else begin
                        we_s    = 1'b1;
                        waddr_s = sec_addr_s;
                        out_d   = sec_s;
                    end
                end
                CMD_POP: begin
                    if (!has1_s) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_UNDER;
                    end else begin
                        out_d = has2_s ? sec_s : '0;
                        cnt_d = cnt_q - (AW+1)'(1);
                    end
                end
                default: begin
                    out_d = out_q;
                end
            endcase
        end else begin
            out_d = out_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            out_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            out_q      <= out_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign out      = out_q;
    assign cnt      = cnt_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
